// File: rtl/logic_op_pipe.sv
// Registered bitwise gate unit (AND/OR/XOR/NAND/NOR/XNOR) returning result c1 and its complement c2, plus flags.
// Latency: 1 cycle from accept to out_valid when the 2-entry output buffer is empty; 1 transfer/cycle sustained.
// Backpressure: in_ready = occupancy < 2, from registered state only; a full buffer ignores a same-cycle pop for push.
module logic_op_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_c1,
  output logic [WIDTH-1:0] out_c2,
  output logic             out_zero,
  output logic             out_ones,
  output logic             out_err,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;

  // Everything the consumer sees is computed once at accept and carried with the entry,
  // so outputs never depend on the operand inputs after the handshake.
  typedef struct packed {
    logic [WIDTH-1:0] c1;
    logic [WIDTH-1:0] c2;
    logic             zero;
    logic             ones;
    logic             err;
  } ent_t;

  ent_t             new_ent;
  logic [WIDTH-1:0] new_c1;
  logic             new_err;

  // head_q always holds the oldest entry; tail_q is only meaningful at occupancy 2.
  ent_t             head_q, head_d;
  ent_t             tail_q, tail_d;
  logic [1:0]       occ_q, occ_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic push;
  logic pop;

  assign in_ready  = (occ_q < 2'd2);
  assign out_valid = (occ_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Evaluate the selected operation; illegal codes store zero with the error flag set.
  always_comb begin
    new_c1  = '0;
    new_err = 1'b0;
    case (in_op)
      OP_AND:  new_c1 = in_a & in_b;
      OP_OR:   new_c1 = in_a | in_b;
      OP_XOR:  new_c1 = in_a ^ in_b;
      OP_NAND: new_c1 = ~(in_a & in_b);
      OP_NOR:  new_c1 = ~(in_a | in_b);
      OP_XNOR: new_c1 = ~(in_a ^ in_b);
      default: begin
        new_c1  = '0;
        new_err = 1'b1;
      end
    endcase
    new_ent.c1   = new_c1;
    new_ent.c2   = ~new_c1;
    new_ent.zero = (new_c1 == '0);
    new_ent.ones = (new_c1 == {WIDTH{1'b1}});
    new_ent.err  = new_err;
  end

  // Buffer next-state: head is never cleared on the last pop, so outputs hold their last values.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    case (occ_q)
      2'd0: begin
        if (push) begin
          head_d = new_ent;
          occ_d  = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = new_ent;
        end else if (push) begin
          tail_d = new_ent;
          occ_d  = 2'd2;
        end else if (pop) begin
          occ_d  = 2'd0;
        end
      end
      2'd2: begin
        if (pop) begin
          head_d = tail_q;
          occ_d  = 2'd1;
        end
      end
      default: occ_d = 2'd0;
    endcase
  end

  // Saturating completion counter; clear wins over a same-cycle pop.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (pop && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers; reset discards any buffered entries immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_c1   = head_q.c1;
  assign out_c2   = head_q.c2;
  assign out_zero = head_q.zero;
  assign out_ones = head_q.ones;
  assign out_err  = head_q.err;
  assign op_count = cnt_q;

endmodule

// File: doc/logic_op_pipe.md
# logic_op_pipe

Parametrised, registered bitwise logic unit: the next generation of the team's two-input gate block. It applies a selectable bitwise operation (AND/OR/XOR/NAND/NOR/XNOR) to two WIDTH-bit operands, and returns both the result and its complement, matching the gate block's c1/c2 pair. Transfers use valid/ready handshakes on both sides, with a 2-entry output buffer, reduction flags and a saturating transaction counter. It sits between an operand producer and any consumer that may stall.

## Interface
- WIDTH, 8, operand/result width in bits (>= 1)
- CNT_W, 16, width of the transaction counter (>= 1)

- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operand set presented
- in_ready  output  1  block can accept an operand set this cycle
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_op  input  3  operation code (see Operation)
- out_valid  output  1  head result valid
- out_ready  input  1  consumer accepts head result
- out_c1  output  WIDTH  operation result
- out_c2  output  WIDTH  bitwise complement of out_c1
- out_zero  output  1  out_c1 == 0
- out_ones  output  1  out_c1 == all ones
- out_err  output  1  head entry came from an illegal in_op
- clr_cnt  input  1  synchronous clear of op_count
- op_count  output  CNT_W  count of completed output handshakes, saturating

## Operation
- in_op encoding:
  - 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR.
  - 6 and 7 are illegal: stored c1 = 0, err = 1.
- Result, complement, zero/ones flags and err are computed at accept and stored per entry. Outputs are driven from the head entry, not recomputed.
- Output buffer holds 2 entries, in-order, with an occupancy counter of 0..2.
- in_ready = (occupancy < 2). It depends only on registered state, never on out_ready.
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- out_valid = (occupancy > 0).
- Simultaneous push and pop at occupancy 1: occupancy stays 1, and the new entry becomes head on the next cycle.
- At occupancy 2 no push is accepted, even if a pop occurs in the same cycle. in_ready rises the cycle after the pop.
- Pop at occupancy 0 is impossible, because out_valid is low.
- Data outputs hold their last head values while out_valid is low. Consumers must ignore them.
- op_count:
  - +1 on each pop.
  - Holds at 2^CNT_W-1 (no wrap).
  - clr_cnt sets it to 0 and takes priority over a same-cycle pop.
- Reset (rst_n low, any time, including mid-transfer):
  - Buffer is emptied and in-flight entries are discarded.
  - Counter is set to 0.
  - Reset values: in_ready=1, out_valid=0, out_c1=0, out_c2=0, out_zero=0, out_ones=0, out_err=0, op_count=0.
  - Release of rst_n takes effect on the next clk edge.

## Timing
- Latency: operands accepted at edge N appear on outputs after edge N, with out_valid high in cycle N+1 (1 cycle) when the buffer was empty.
- Throughput: 1 transfer/cycle while out_ready is held high.
- in_ready stays high continuously when every result is popped the cycle it appears.
- A stall of k cycles with continuous input fills the buffer:
  - in_ready drops after 2 accepted entries.
  - The entry order at the output is preserved.
- All outputs are registered or derived from registered state only. There is no combinational path from in_* or out_ready to any output.

## Test plan
- Reset then idle: assert rst_n=0 mid-stream with occupancy 2. Required: out_valid=0, in_ready=1, op_count=0 immediately (async); no stale entry after release.
- All ops, WIDTH=8: A=0xCA, B=0x5C, op 0..5, out_ready=1. Required out_c1 values and out_c2 = ~out_c1:
  - AND 0x48, OR 0xDE, XOR 0x96.
  - NAND 0xB7, NOR 0x21, XNOR 0x69.
  - Each appears 1 cycle after accept.
- Flags/illegal:
  - A=0xFF, B=0xFF, op 0: out_ones=1, out_zero=0.
  - A=0x0F, B=0xF0, op 0: out_zero=1.
  - op 6: out_c1=0x00, out_c2=0xFF, out_err=1.
- Backpressure: out_ready=0, drive 3 sets back-to-back.
  - Required: 2 accepted, then in_ready=0.
  - Release out_ready: results pop in order; in_ready returns 1 the cycle after the first pop. The 3rd set, still presented, is accepted then.
- Streaming: 20 sets with out_ready=1 every cycle. Required: in_ready never drops, 20 results in order, op_count=20.
- Counter (CNT_W=2): 5 pops.
  - Required: op_count sequence 1,2,3,3,3.
  - clr_cnt together with a pop gives op_count=0.
